// File: rtl/fir_pkg.sv
// Shared definitions for the serial-MAC FIR filter: FSM state encoding and
// the full-precision accumulator width.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    CALC       = 2'd1,
    SET_OUTPUT = 2'd2,
    CONFIG     = 2'd3
  } fir_state_t;

  // Product width plus growth for summing n_taps products.
  function automatic int unsigned acc_width(input int unsigned x_size,
                                            input int unsigned tap_size,
                                            input int unsigned n_taps);
    return x_size + tap_size + $clog2(n_taps);
  endfunction

endpackage

// File: rtl/fir_out_reduce.sv
// Output reduction for the FIR accumulator: arithmetic right shift, then
// narrowing to the output width. Define FIR_SATURATE_EN to clamp to the
// signed output range; otherwise the low bits are kept (two's-complement wrap).
module fir_out_reduce #(
  parameter int unsigned ACC_W     = 15,
  parameter int unsigned Y_N_SIZE  = 12,
  parameter int unsigned OUT_SHIFT = 0
) (
  input  logic [ACC_W-1:0]    acc,
  output logic [Y_N_SIZE-1:0] y
);

  // One guard bit above the wider of the two widths keeps comparisons signed-safe.
  localparam int unsigned W = ((ACC_W > Y_N_SIZE) ? ACC_W : Y_N_SIZE) + 1;

  logic signed [W-1:0] shifted;

  assign shifted = W'($signed(acc) >>> OUT_SHIFT);

`ifdef FIR_SATURATE_EN
  localparam logic signed [W-1:0] Y_MAX = {{(W-Y_N_SIZE+1){1'b0}}, {(Y_N_SIZE-1){1'b1}}};
  localparam logic signed [W-1:0] Y_MIN = ~Y_MAX;

  // Clamp to [-2^(Y_N_SIZE-1), 2^(Y_N_SIZE-1)-1].
  always_comb begin
    y = shifted[Y_N_SIZE-1:0];
    if (shifted > Y_MAX) begin
      y = Y_MAX[Y_N_SIZE-1:0];
    end else if (shifted < Y_MIN) begin
      y = Y_MIN[Y_N_SIZE-1:0];
    end
  end
`else
  assign y = Y_N_SIZE'(shifted);
`endif

endmodule

// File: rtl/fir_serial_mac.sv
// Serial FIR filter: one multiply-accumulate per clock over NBR_OF_TAPS taps,
// with an AXI-stream-style sample handshake and a shift-in coefficient port.
// Optional macro FIR_SATURATE_EN selects output saturation instead of wrap.
module fir_serial_mac
  import fir_pkg::*;
#(
  parameter int unsigned TAP_SIZE    = 4,
  parameter int unsigned NBR_OF_TAPS = 8,
  parameter int unsigned X_N_SIZE    = 8,
  parameter int unsigned Y_N_SIZE    = 12,
  parameter int unsigned OUT_SHIFT   = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [X_N_SIZE-1:0] x_n,
  input  logic                s_axis_fir_tvalid,
  output logic                s_axis_fir_tready,
  input  logic                s_set_coeffs,
  input  logic                s_coeff_valid,
  input  logic [TAP_SIZE-1:0] s_coeff,
  output logic [Y_N_SIZE-1:0] o_y_n,
  output logic                o_y_valid
);

  localparam int unsigned ACC_W = acc_width(X_N_SIZE, TAP_SIZE, NBR_OF_TAPS);
  localparam int unsigned K_W   = $clog2(NBR_OF_TAPS);
  localparam int unsigned P_W   = X_N_SIZE + TAP_SIZE;

  fir_state_t state, state_next;

  logic signed [TAP_SIZE-1:0] taps  [NBR_OF_TAPS];
  logic signed [X_N_SIZE-1:0] buffs [NBR_OF_TAPS];
  logic signed [ACC_W-1:0]    acc, acc_next;
  logic signed [P_W-1:0]      prod;
  logic [K_W-1:0]             k;
  logic                       last_tap;
  logic                       accept;
  logic [Y_N_SIZE-1:0]        y_reduced;

  assign s_axis_fir_tready = (state == IDLE) & ~s_set_coeffs;
  assign last_tap          = (k == K_W'(NBR_OF_TAPS - 1));
  assign prod              = taps[k] * buffs[k];
  assign acc_next          = acc + ACC_W'(prod);

  fir_out_reduce #(
    .ACC_W    (ACC_W),
    .Y_N_SIZE (Y_N_SIZE),
    .OUT_SHIFT(OUT_SHIFT)
  ) u_reduce (
    .acc(acc_next),
    .y  (y_reduced)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; coefficient mode takes priority over an offered sample.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (s_set_coeffs) begin
          state_next = CONFIG;
        end else if (s_axis_fir_tvalid) begin
          accept     = 1'b1;
          state_next = CALC;
        end
      end
      CALC: begin
        if (last_tap) begin
          state_next = SET_OUTPUT;
        end
      end
      SET_OUTPUT: state_next = IDLE;
      CONFIG: begin
        if (!s_set_coeffs) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: delay line, MAC, coefficient shift register and output register.
  // The result is captured from the final MAC sum on the edge entering
  // SET_OUTPUT, so o_y_n and o_y_valid are both presented during SET_OUTPUT.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NBR_OF_TAPS; i++) begin
        taps[i]  <= '0;
        buffs[i] <= '0;
      end
      acc       <= '0;
      k         <= '0;
      o_y_n     <= '0;
      o_y_valid <= 1'b0;
    end else begin
      o_y_valid <= 1'b0;
      if (accept) begin
        for (int unsigned i = 1; i < NBR_OF_TAPS; i++) begin
          buffs[i] <= buffs[i-1];
        end
        buffs[0] <= x_n;
        acc      <= '0;
        k        <= '0;
      end
      if (state == CALC) begin
        acc <= acc_next;
        k   <= last_tap ? '0 : k + 1'b1;
        if (last_tap) begin
          o_y_n     <= y_reduced;
          o_y_valid <= 1'b1;
        end
      end
      if ((state == CONFIG) && s_coeff_valid) begin
        for (int unsigned i = 1; i < NBR_OF_TAPS; i++) begin
          taps[i] <= taps[i-1];
        end
        taps[0] <= s_coeff;
      end
    end
  end

endmodule

// File: tb/tb_fir_serial_mac.sv
// Scoreboard bench for fir_serial_mac at default parameters: stimulus pushes
// hand-computed results, a monitor pops and compares on every o_y_valid.
module tb_fir_serial_mac;

  localparam int N = 8;
  typedef int tap_arr_t [N];

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  x_n = '0;
  logic        tvalid = 1'b0;
  logic        tready;
  logic        set_c = 1'b0;
  logic        c_valid = 1'b0;
  logic [3:0]  coeff = '0;
  logic [11:0] y_n;
  logic        y_valid;

  int n_pass  = 0;
  int n_total = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  fir_serial_mac #(
    .TAP_SIZE   (4),
    .NBR_OF_TAPS(N),
    .X_N_SIZE   (8),
    .Y_N_SIZE   (12),
    .OUT_SHIFT  (0)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .x_n              (x_n),
    .s_axis_fir_tvalid(tvalid),
    .s_axis_fir_tready(tready),
    .s_set_coeffs     (set_c),
    .s_coeff_valid    (c_valid),
    .s_coeff          (coeff),
    .o_y_n            (y_n),
    .o_y_valid        (y_valid)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      if (tready) break;
      tick();
    end
    chk("idle_reached", int'(tready), 1);
  endtask

  // Last coefficient is shifted in the same cycle set_coeffs drops.
  task automatic load_taps(input tap_arr_t t);
    set_c   = 1'b1;
    c_valid = 1'b0;
    tick();
    for (int i = N - 1; i >= 0; i--) begin
      coeff   = 4'(t[i]);
      c_valid = 1'b1;
      if (i == 0) set_c = 1'b0;
      tick();
    end
    c_valid = 1'b0;
  endtask

  task automatic send(input int x, input bit push, input int expv);
    wait_idle();
    x_n    = 8'(x);
    tvalid = 1'b1;
    if (push) exp_q.push_back(expv);
    tick();
    tvalid = 1'b0;
  endtask

  tap_arr_t ramp, ones, sevens;
  // Tap value 8 does not fit a 4-bit signed coefficient; it loads as -8.
  int imp_exp[N+1] = '{1, 2, 3, 4, 5, 6, 7, -8, 0};
`ifdef FIR_SATURATE_EN
  int ovf_exp[N] = '{889, 1778, 2047, 2047, 2047, 2047, 2047, 2047};
`else
  int ovf_exp[N] = '{889, 1778, -1429, -540, 349, 1238, -1969, -1080};
`endif

  initial begin
    for (int i = 0; i < N; i++) begin
      ramp[i]   = i + 1;
      ones[i]   = 1;
      sevens[i] = 7;
    end

    fork
      forever begin
        @(negedge clk);
        if (y_valid === 1'b1) begin
          if (exp_q.size() == 0) chk("unexpected_valid", int'(y_valid), 0);
          else chk("y_n", int'($signed(y_n)), exp_q.pop_front());
        end
      end
      begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset state
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_y_n", int'(y_n), 0);
    chk("rst_y_valid", int'(y_valid), 0);
    chk("rst_tready", int'(tready), 1);

    // Impulse response; first sample also checks latency and tready timing
    load_taps(ramp);
    wait_idle();
    x_n    = 8'd1;
    tvalid = 1'b1;
    exp_q.push_back(imp_exp[0]);
    tick();
    tvalid = 1'b0;
    for (int c = 1; c <= N + 1; c++) begin
      chk($sformatf("latency_cyc%0d", c), int'({tready, y_valid}), (c == N + 1) ? 1 : 0);
      tick();
    end
    chk("tready_after_result", int'(tready), 1);
    for (int i = 1; i <= N; i++) send(0, 1'b1, imp_exp[i]);
    wait_idle();

    // Collision: coefficient request wins over an offered sample
    send(3, 1'b1, 3);
    wait_idle();
    set_c  = 1'b1;
    tvalid = 1'b1;
    x_n    = 8'd5;
    #1;
    chk("collision_tready", int'(tready), 0);
    tick();
    tvalid = 1'b0;
    chk("config_tready", int'(tready), 0);
    for (int i = N - 1; i >= 0; i--) begin
      coeff   = 4'(ones[i]);
      c_valid = 1'b1;
      set_c   = (i != 0);
      tick();
    end
    c_valid = 1'b0;
    send(0, 1'b1, 3);  // line [0,3,0..] -> 3; 8 had the rejected 5 entered
    wait_idle();

    // Reset in the middle of CALC: no result, taps and delay line cleared
    load_taps(ramp);
    send(1, 1'b0, 0);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midcalc_tready", int'(tready), 1);
    chk("midcalc_y_n", int'(y_n), 0);
    chk("midcalc_y_valid", int'(y_valid), 0);
    send(1, 1'b1, 0);
    wait_idle();
    load_taps(ramp);
    send(1, 1'b1, 3);  // line [1,1,0..] with ramp taps

    // Coefficient request during CALC waits; result uses the old taps
    set_c = 1'b1;
    tick();
    chk("set_in_calc_tready", int'(tready), 0);
    repeat (N + 2) tick();
    set_c = 1'b0;
    wait_idle();

    // Overflow with full-scale taps and samples
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    load_taps(sevens);
    for (int i = 0; i < N; i++) send(127, 1'b1, ovf_exp[i]);
    wait_idle();

    repeat (3) tick();
    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
